// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants so the fetch, branch and memory blocks agree on
// the datapath width and the reset vector.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/program_counter.sv
// Fetch-stage PC register: captures the upstream next-PC each cycle, with
// optional low-bit alignment masking and a synchronous reset to a fixed vector.
module program_counter
    import cpu_pkg::*;
#(
    parameter int unsigned     WIDTH        = XLEN,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(cpu_pkg::RESET_VECTOR),
    parameter int unsigned     ALIGN_BITS   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] next,
    output logic [WIDTH-1:0] ppc
);

    // All ones above the alignment field; all ones when ALIGN_BITS == 0.
    localparam logic [WIDTH-1:0] ALIGN_MASK =
        ~((WIDTH'(1) << ALIGN_BITS) - WIDTH'(1));

    generate
        if (ALIGN_BITS >= WIDTH) begin : g_bad_align
            $error("program_counter: ALIGN_BITS must be less than WIDTH");
        end
        if ((RESET_VECTOR & ~ALIGN_MASK) != '0) begin : g_bad_vector
            $error("program_counter: RESET_VECTOR is not aligned to ALIGN_BITS");
        end
    endgenerate

    logic [WIDTH-1:0] pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= next & ALIGN_MASK;
        end
    end

    assign ppc = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: one default instance and one with word
// alignment and a non-zero reset vector, sharing clock and reset.
module tb_program_counter;

    logic        clk;
    logic        reset;
    logic [31:0] next_a;
    logic [31:0] next_b;
    logic [31:0] ppc_a;
    logic [31:0] ppc_b;

    int checks;
    int failures;

    program_counter u_pc_a (
        .clk   (clk),
        .reset (reset),
        .next  (next_a),
        .ppc   (ppc_a)
    );

    program_counter #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0000_0100),
        .ALIGN_BITS   (2)
    ) u_pc_b (
        .clk   (clk),
        .reset (reset),
        .next  (next_b),
        .ppc   (ppc_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        next_a   = 32'h0;
        next_b   = 32'h0;

        tick();
        chk("reset_a", ppc_a, 32'h0000_0000);
        chk("reset_b", ppc_b, 32'h0000_0100);

        reset  = 1'b0;
        next_a = 32'h1;
        next_b = 32'h107;
        tick();
        chk("load1", ppc_a, 32'h1);
        chk("align_107", ppc_b, 32'h104);

        next_a = 32'h2;
        #3;
        chk("hold_between_edges", ppc_a, 32'h1);
        tick();
        chk("load2", ppc_a, 32'h2);

        next_a = 32'h3;
        next_b = 32'hFFFF_FFFF;
        tick();
        chk("load3", ppc_a, 32'h3);
        chk("align_ffff", ppc_b, 32'hFFFF_FFFC);

        reset = 1'b1;
        tick();
        chk("midrun_reset_a", ppc_a, 32'h0);
        chk("midrun_reset_b", ppc_b, 32'h100);

        reset  = 1'b0;
        next_a = 32'h4;
        tick();
        chk("after_reset_load", ppc_a, 32'h4);

        reset  = 1'b1;
        next_a = 32'hDEAD_BEEF;
        next_b = 32'hDEAD_BEEF;
        tick();
        chk("priority_a", ppc_a, 32'h0);
        chk("priority_b", ppc_b, 32'h100);

        reset  = 1'b0;
        next_a = 32'hFFFF_FFFF;
        tick();
        chk("max_value", ppc_a, 32'hFFFF_FFFF);
        chk("priority_release_b", ppc_b, 32'hDEAD_BEEC);

        next_a = 32'h0;
        tick();
        chk("max_to_zero", ppc_a, 32'h0);

        // Reset pulse that is low again by the edge must be ignored.
        next_a = 32'h5;
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        tick();
        chk("reset_glitch", ppc_a, 32'h5);

        next_a = 32'h6;
        next_b = 32'h13;
        tick();
        chk("load6", ppc_a, 32'h6);
        chk("align_13", ppc_b, 32'h10);

        next_b = 32'h13;
        tick();
        chk("repeat_next", ppc_b, 32'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
